// File: rtl/adder_share_arbiter.sv
// -----------------------------------------------------------------------------
// adder_share_arbiter
//
// Shares a single external W-bit add/sub unit between two requesters using
// round-robin arbitration. The winner's operands are latched onto the unit's
// input buses and held for SETTLE_CYCLES cycles so the ripple path settles.
// The unit's sum and overflow are then captured, and a one-cycle done pulse
// goes to the winner.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   req0/sub0/a0_in/b0_in requester 0: level request, op (1 = A-B), operands
//   req1/sub1/a1_in/b1_in requester 1: same as requester 0
//   add_sub/add_a/add_b   operand/op buses driven into the shared adder
//   add_c/add_ovf         result and signed-overflow returned by the adder
//   gnt                   one-hot grant, high while requester i owns the unit
//   busy                  high while an op is in flight (ISSUE and DONE)
//   done0/done1           one-cycle pulse, result/ovf valid for requester i
//   result/ovf            captured adder output of the last completed op
// -----------------------------------------------------------------------------
module adder_share_arbiter #(
    parameter int W             = 15,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         sub0,
    input  logic [W-1:0] a0_in,
    input  logic [W-1:0] b0_in,
    input  logic         req1,
    input  logic         sub1,
    input  logic [W-1:0] a1_in,
    input  logic [W-1:0] b1_in,
    output logic         add_sub,
    output logic [W-1:0] add_a,
    output logic [W-1:0] add_b,
    input  logic [W-1:0] add_c,
    input  logic         add_ovf,
    output logic [1:0]   gnt,
    output logic         busy,
    output logic         done0,
    output logic         done1,
    output logic [W-1:0] result,
    output logic         ovf
);

    // Counter only has to hold SETTLE_CYCLES-1 down to 0.
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DONE
    } state_t;

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic          last_reg;   // index of the most recently granted requester

    logic any_req;
    logic win;                 // 0 = requester 0 wins, 1 = requester 1 wins

    assign any_req = req0 | req1;
    // A lone requester always wins; on contention the one not served last wins.
    assign win     = (req0 & req1) ? ~last_reg : req1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            last_reg  <= 1'b1;   // requester 0 wins the first contention
            add_sub   <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
            gnt       <= 2'b00;
            busy      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            result    <= '0;
            ovf       <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (any_req) begin
                        state_reg <= ST_ISSUE;
                        cnt_reg   <= CW'(SETTLE_CYCLES - 1);
                        last_reg  <= win;
                        gnt       <= win ? 2'b10 : 2'b01;
                        busy      <= 1'b1;
                        add_sub   <= win ? sub1  : sub0;
                        add_a     <= win ? a1_in : a0_in;
                        add_b     <= win ? b1_in : b0_in;
                    end
                end

                ST_ISSUE: begin
                    // Operand buses are left untouched here so the adder settles.
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end else begin
                        result    <= add_c;
                        ovf       <= add_ovf;
                        done0     <= gnt[0];
                        done1     <= gnt[1];
                        state_reg <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    done0     <= 1'b0;
                    done1     <= 1'b0;
                    gnt       <= 2'b00;
                    busy      <= 1'b0;
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
